// File: rtl/sram_ctrl_pkg.sv
// Shared types for the async-SRAM controller: FSM state encoding and wait-counter width.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2,
    StTurn   = 2'd3
  } state_e;

  // Wide enough for WAIT_CYCLES in 0..15.
  localparam int unsigned WaitW = 4;

endpackage

// File: rtl/sram_ctrl_if.sv
// Core-side request/response channel of the SRAM controller; master = core, slave = controller.
interface sram_ctrl_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wmask;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_ctrl_io.sv
// Tristate pad for the SRAM data bus: drives i_data when i_oe, always returns the pad value.
module sram_ctrl_io #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_oe,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  inout  wire  [DATA_W-1:0] io_pad
);
  assign io_pad = i_oe ? i_data : {DATA_W{1'bz}};
  assign o_data = io_pad;
endmodule

// File: rtl/sram_ctrl.sv
// Async-SRAM controller: one outstanding access, registered pins, WAIT_CYCLES wait states.
// Optional feature macro: SRAM_CTRL_TURNAROUND_EN adds a bus turnaround cycle after writes.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst,
  sram_ctrl_if.slave          bus,
  inout  wire  [DATA_W-1:0]   sram_data,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W/8-1:0] sram_be_n,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n
);
  localparam int unsigned MASK_W = DATA_W / 8;

  state_e              r_state, w_state_d;
  logic [WaitW-1:0]    r_wait_cnt;
  logic                r_op_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [MASK_W-1:0]   r_be_n, w_be_n_d;
  logic                r_ce_n, w_ce_n_d;
  logic                r_oe_n, w_oe_n_d;
  logic                r_we_n, w_we_n_d;
  logic                r_data_oe, w_data_oe_d;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic [DATA_W-1:0]   w_din;
  logic                w_accept, w_op_we, w_access_done;

  assign bus.req_ready = (r_state == StIdle) && !rst;
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign w_op_we       = w_accept ? bus.req_we : r_op_we;
  assign w_access_done = (r_state == StAccess) && (r_wait_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_accept) w_state_d = StAccess;
      StAccess: if (r_wait_cnt == '0) w_state_d = StResp;
`ifdef SRAM_CTRL_TURNAROUND_EN
      StResp:   w_state_d = r_op_we ? StTurn : StIdle;
`else
      StResp:   w_state_d = StIdle;
`endif
      StTurn:   w_state_d = StIdle;
    endcase
  end

  // Next pin values; the mask is taken from the request on accept and then held.
  always_comb begin
    w_ce_n_d    = 1'b1;
    w_oe_n_d    = 1'b1;
    w_we_n_d    = 1'b1;
    w_be_n_d    = '1;
    w_data_oe_d = 1'b0;
    if (w_state_d == StAccess) begin
      w_ce_n_d = 1'b0;
      if (w_op_we) begin
        w_we_n_d    = 1'b0;
        w_be_n_d    = w_accept ? ~bus.req_wmask : r_be_n;
        w_data_oe_d = 1'b1;
      end else begin
        w_oe_n_d = 1'b0;
        w_be_n_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_be_n      <= '1;
      r_data_oe   <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_op_we     <= 1'b0;
      r_wait_cnt  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_ce_n      <= w_ce_n_d;
      r_oe_n      <= w_oe_n_d;
      r_we_n      <= w_we_n_d;
      r_be_n      <= w_be_n_d;
      r_data_oe   <= w_data_oe_d;
      r_rsp_valid <= w_access_done;
      if (w_accept) begin
        r_addr     <= bus.req_addr;
        r_wdata    <= bus.req_wdata;
        r_op_we    <= bus.req_we;
        r_wait_cnt <= WaitW'(WAIT_CYCLES);
      end else if ((r_state == StAccess) && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - 1'b1;
      end
      // Read data is captured on the last access cycle; write acks return zero.
      if (w_access_done) r_rsp_rdata <= r_op_we ? '0 : w_din;
    end
  end

  sram_ctrl_io #(
    .DATA_W(DATA_W)
  ) u_io (
    .i_oe  (r_data_oe),
    .i_data(r_wdata),
    .o_data(w_din),
    .io_pad(sram_data)
  );

  assign sram_addr     = r_addr;
  assign sram_be_n     = r_be_n;
  assign sram_ce_n     = r_ce_n;
  assign sram_oe_n     = r_oe_n;
  assign sram_we_n     = r_we_n;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: a WAIT_CYCLES=0 instance with a fixed-pattern SRAM and a
// WAIT_CYCLES=2 instance with a small byte-masked SRAM model.
module tb_sram_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sram_ctrl_if #(.ADDR_W(20), .DATA_W(32)) if0 ();
  sram_ctrl_if #(.ADDR_W(20), .DATA_W(32)) if2 ();

  wire  [31:0] d0;
  wire  [31:0] d2;
  logic [19:0] a0, a2;
  logic [3:0]  be0, be2;
  logic        ce0, oe0, we0, ce2, oe2, we2;

  sram_ctrl #(.ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(0)) u_dut0 (
    .clk      (clk),
    .rst      (rst),
    .bus      (if0),
    .sram_data(d0),
    .sram_addr(a0),
    .sram_be_n(be0),
    .sram_ce_n(ce0),
    .sram_oe_n(oe0),
    .sram_we_n(we0)
  );

  sram_ctrl #(.ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(2)) u_dut2 (
    .clk      (clk),
    .rst      (rst),
    .bus      (if2),
    .sram_data(d2),
    .sram_addr(a2),
    .sram_be_n(be2),
    .sram_ce_n(ce2),
    .sram_oe_n(oe2),
    .sram_we_n(we2)
  );

  // SRAM behind instance 0 always reads back a fixed pattern.
  assign d0 = (!ce0 && !oe0 && we0) ? 32'hDEADBEEF : 32'hzzzzzzzz;

  logic [31:0] mem2 [0:63];
  assign d2 = (!ce2 && !oe2 && we2) ? mem2[a2[5:0]] : 32'hzzzzzzzz;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem2[i] <= 32'hFFFFFFFF;
    end else if (!ce2 && !we2) begin
      for (int b = 0; b < 4; b++)
        if (!be2[b]) mem2[a2[5:0]][8*b +: 8] <= d2[8*b +: 8];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    if0.req_valid = 1'b0; if0.req_we = 1'b0; if0.req_addr = '0;
    if0.req_wdata = '0;   if0.req_wmask = '0;
    if2.req_valid = 1'b0; if2.req_we = 1'b0; if2.req_addr = '0;
    if2.req_wdata = '0;   if2.req_wmask = '0;

    // Reset state
    repeat (3) tick();
    check("rst_ce_n",  ce0, 1);
    check("rst_oe_n",  oe0, 1);
    check("rst_we_n",  we0, 1);
    check("rst_be_n",  be0, 4'hF);
    check("rst_drive", u_dut0.r_data_oe, 0);
    check("rst_ready", if0.req_ready, 0);
    check("rst_rspv",  if0.rsp_valid, 0);
    check("rst_rdata", if0.rsp_rdata, 0);
    check("rst_addr",  a0, 0);
    check("rst_ce2",   ce2, 1);
    rst = 1'b0;
    tick();
    check("idle_ready0", if0.req_ready, 1);
    check("idle_ready2", if2.req_ready, 1);

    // WAIT=0 read of 0x00010
    if0.req_valid = 1'b1; if0.req_we = 1'b0; if0.req_addr = 20'h00010;
    tick();
    check("rd0_oe_n",  oe0, 0);
    check("rd0_ce_n",  ce0, 0);
    check("rd0_we_n",  we0, 1);
    check("rd0_be_n",  be0, 4'h0);
    check("rd0_addr",  a0, 20'h00010);
    check("rd0_drive", u_dut0.r_data_oe, 0);
    check("rd0_rdy",   if0.req_ready, 0);
    check("rd0_rspv0", if0.rsp_valid, 0);
    if0.req_valid = 1'b0;
    tick();
    check("rd0_oe_off", oe0, 1);
    check("rd0_rspv",   if0.rsp_valid, 1);
    check("rd0_rdata",  if0.rsp_rdata, 32'hDEADBEEF);
    tick();
    check("rd0_rspv_pulse", if0.rsp_valid, 0);
    check("rd0_rdy_back",   if0.req_ready, 1);

    // WAIT=2 masked write of 0x12345678 to 0x00020 over 0xFFFFFFFF
    if2.req_valid = 1'b1; if2.req_we = 1'b1; if2.req_addr = 20'h00020;
    if2.req_wdata = 32'h12345678; if2.req_wmask = 4'b0101;
    tick();
    check("wr2_we_n1", we2, 0);
    check("wr2_ce_n",  ce2, 0);
    check("wr2_oe_n",  oe2, 1);
    check("wr2_be_n",  be2, 4'b1010);
    check("wr2_data",  d2, 32'h12345678);
    check("wr2_addr",  a2, 20'h00020);
    if2.req_valid = 1'b0;
    tick();
    check("wr2_we_n2", we2, 0);
    tick();
    check("wr2_we_n3", we2, 0);
    check("wr2_rspv0", if2.rsp_valid, 0);
    tick();
    check("wr2_we_off", we2, 1);
    check("wr2_drive",  u_dut2.r_data_oe, 0);
    check("wr2_rspv",   if2.rsp_valid, 1);
    check("wr2_ack0",   if2.rsp_rdata, 0);
    check("wr2_mem",    mem2[32], 32'hFF34FF78);
    tick();
    check("wr2_rspv_pulse", if2.rsp_valid, 0);
    for (int i = 0; i < 8 && !if2.req_ready; i++) tick();
    check("wr2_ready_wait", if2.req_ready, 1);

    // Readback of 0x00020
    if2.req_valid = 1'b1; if2.req_we = 1'b0; if2.req_addr = 20'h00020;
    tick();
    check("rb2_oe_n", oe2, 0);
    check("rb2_be_n", be2, 4'h0);
    if2.req_valid = 1'b0;
    repeat (3) tick();
    check("rb2_rspv",  if2.rsp_valid, 1);
    check("rb2_rdata", if2.rsp_rdata, 32'hFF34FF78);

    // Back-to-back write then read on WAIT=0; the read is presented while not ready
    if0.req_valid = 1'b1; if0.req_we = 1'b1; if0.req_addr = 20'h00005;
    if0.req_wdata = 32'hAAAA5555; if0.req_wmask = 4'hF;
    check("b2b_rdy_t", if0.req_ready, 1);
    tick();
    check("b2b_we_n", we0, 0);
    check("b2b_rdy1", if0.req_ready, 0);
    if0.req_we = 1'b0;
    tick();
    check("b2b_rspv", if0.rsp_valid, 1);
    check("b2b_ack0", if0.rsp_rdata, 0);
    check("b2b_rdy2", if0.req_ready, 0);
    tick();
`ifdef SRAM_CTRL_TURNAROUND_EN
    check("b2b_turn_rdy",  if0.req_ready, 0);
    check("b2b_turn_ce",   ce0, 1);
    check("b2b_turn_oe",   oe0, 1);
    check("b2b_turn_drv",  u_dut0.r_data_oe, 0);
    tick();
`endif
    check("b2b_rdy3", if0.req_ready, 1);
    tick();
    check("b2b_rd_oe_n", oe0, 0);
    check("b2b_rd_we_n", we0, 1);
    if0.req_valid = 1'b0;
    tick();
    check("b2b_rd_rspv",  if0.rsp_valid, 1);
    check("b2b_rd_rdata", if0.rsp_rdata, 32'hDEADBEEF);

    // wmask=0 write on WAIT=2 leaves memory untouched
    for (int i = 0; i < 8 && !if2.req_ready; i++) tick();
    check("wm0_ready_wait", if2.req_ready, 1);
    if2.req_valid = 1'b1; if2.req_we = 1'b1; if2.req_addr = 20'h00020;
    if2.req_wdata = 32'hAAAAAAAA; if2.req_wmask = 4'h0;
    tick();
    check("wm0_be_n", be2, 4'hF);
    check("wm0_we_n", we2, 0);
    if2.req_valid = 1'b0;
    repeat (3) tick();
    check("wm0_rspv", if2.rsp_valid, 1);
    check("wm0_mem",  mem2[32], 32'hFF34FF78);

    // Reset in the second access cycle of a write aborts with no response
    for (int i = 0; i < 8 && !if2.req_ready; i++) tick();
    check("rsa_ready_wait", if2.req_ready, 1);
    if2.req_valid = 1'b1; if2.req_we = 1'b1; if2.req_addr = 20'h00021;
    if2.req_wdata = 32'h0; if2.req_wmask = 4'hF;
    tick();
    if2.req_valid = 1'b0;
    tick();
    check("rsa_we_n_mid", we2, 0);
    rst = 1'b1;
    tick();
    check("rsa_ce_n",  ce2, 1);
    check("rsa_we_n",  we2, 1);
    check("rsa_be_n",  be2, 4'hF);
    check("rsa_drive", u_dut2.r_data_oe, 0);
    check("rsa_rspv",  if2.rsp_valid, 0);
    check("rsa_ready", if2.req_ready, 0);
    rst = 1'b0;
    tick();
    check("rsa_rspv_after",  if2.rsp_valid, 0);
    check("rsa_ready_after", if2.req_ready, 1);
    tick();
    check("rsa_rspv_late", if2.rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
